// File: rtl/if_stage_fetch_pkg.sv
// Shared widths, instruction encodings and controller states for the fetch stage.
package if_pkg;
    localparam int N_BITS    = 32;
    localparam int MEM_DEPTH = 256;
    localparam int ADDR_BITS = 8;

    localparam logic [N_BITS-1:0] NOP_WORD  = '0;
    localparam logic [N_BITS-1:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;
endpackage

// File: rtl/if_stage_fetch_if.sv
// Loader, debug and hazard-detector signals of the fetch stage, plus its IF/ID outputs.
interface if_stage_fetch_if;
    import if_pkg::*;

    logic                 i_wr_en;
    logic [ADDR_BITS-1:0] i_wr_addr;
    logic [N_BITS-1:0]    i_wr_data;
    logic                 i_start;
    logic                 i_enable;
    logic                 i_halt;
    logic                 i_flush;
    logic [N_BITS-1:0]    i_jump_direction;
    logic [N_BITS-1:0]    o_pc;
    logic [N_BITS-1:0]    o_instruction;
    logic [N_BITS-1:0]    o_pc_plus4;
    logic                 o_halted;
    logic [N_BITS-1:0]    o_cycle_count;

    modport master (
        output i_wr_en, i_wr_addr, i_wr_data, i_start, i_enable,
               i_halt, i_flush, i_jump_direction,
        input  o_pc, o_instruction, o_pc_plus4, o_halted, o_cycle_count
    );

    modport slave (
        input  i_wr_en, i_wr_addr, i_wr_data, i_start, i_enable,
               i_halt, i_flush, i_jump_direction,
        output o_pc, o_instruction, o_pc_plus4, o_halted, o_cycle_count
    );
endinterface

// File: rtl/if_stage_fetch_instr_mem.sv
// Instruction memory: synchronous write port for the loader, asynchronous read for fetch.
module instr_mem #(
    parameter int N_BITS    = 32,
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_BITS = $clog2(MEM_DEPTH)
) (
    input  logic                 i_clk,
    input  logic                 i_wr_en,
    input  logic [ADDR_BITS-1:0] i_wr_addr,
    input  logic [N_BITS-1:0]    i_wr_data,
    input  logic [ADDR_BITS-1:0] i_rd_addr,
    output logic [N_BITS-1:0]    o_rd_data
);
    logic [N_BITS-1:0] r_mem [MEM_DEPTH];

    // Contents deliberately survive reset so a loaded program can be re-run.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];
endmodule

// File: rtl/if_stage_fetch.sv
// Fetch stage: PC, loadable instruction memory and IF/ID register under an IDLE/RUN/HALTED controller.
// Define IFETCH_CYCLE_COUNTER_EN to count RUN cycles on o_cycle_count (tied to 0 otherwise).
//
// state   | meaning
// IDLE    | loader may write memory; waiting for i_start
// RUN     | fetching, gated by i_enable, i_halt and i_flush
// HALTED  | HALT word fetched; only reset leaves
module if_stage_fetch
    import if_pkg::*;
(
    input logic             i_clk,
    input logic             i_reset,
    if_stage_fetch_if.slave bus
);
    fetch_state_e      r_state, w_state_next;
    logic [N_BITS-1:0] r_pc, w_pc_next;
    logic [N_BITS-1:0] r_instruction, w_instruction_next;
    logic [N_BITS-1:0] r_pc_plus4, w_pc_plus4_next;
    logic [N_BITS-1:0] w_pc_inc;
    logic [N_BITS-1:0] w_rd_data;
    logic              r_halted, w_halted_next;
    logic              w_mem_we;

    assign w_mem_we = bus.i_wr_en && (r_state == ST_IDLE);
    assign w_pc_inc = r_pc + N_BITS'(4);

    instr_mem #(
        .N_BITS    (N_BITS),
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_instr_mem (
        .i_clk     (i_clk),
        .i_wr_en   (w_mem_we),
        .i_wr_addr (bus.i_wr_addr),
        .i_wr_data (bus.i_wr_data),
        .i_rd_addr (r_pc[ADDR_BITS+1:2]),
        .o_rd_data (w_rd_data)
    );

    always_comb begin
        w_state_next       = r_state;
        w_pc_next          = r_pc;
        w_instruction_next = r_instruction;
        w_pc_plus4_next    = r_pc_plus4;
        w_halted_next      = r_halted;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_start) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // A stall wins over a flush; the branch re-resolves once the stall clears.
                if (bus.i_enable && !bus.i_halt) begin
                    if (bus.i_flush) begin
                        w_pc_next          = bus.i_jump_direction;
                        w_instruction_next = NOP_WORD;
                        w_pc_plus4_next    = '0;
                    end else begin
                        w_instruction_next = w_rd_data;
                        w_pc_plus4_next    = w_pc_inc;
                        if (w_rd_data == HALT_WORD) begin
                            w_halted_next = 1'b1;
                            w_state_next  = ST_HALTED;
                        end else begin
                            w_pc_next = w_pc_inc;
                        end
                    end
                end
            end
            ST_HALTED: begin
                w_state_next = ST_HALTED;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state       <= ST_IDLE;
            r_pc          <= '0;
            r_instruction <= NOP_WORD;
            r_pc_plus4    <= '0;
            r_halted      <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_instruction <= w_instruction_next;
            r_pc_plus4    <= w_pc_plus4_next;
            r_halted      <= w_halted_next;
        end
    end

`ifdef IFETCH_CYCLE_COUNTER_EN
    logic [N_BITS-1:0] r_cycle_count;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cycle_count <= '0;
        end else if (r_state == ST_RUN) begin
            r_cycle_count <= r_cycle_count + N_BITS'(1);
        end
    end

    assign bus.o_cycle_count = r_cycle_count;
`else
    assign bus.o_cycle_count = '0;
`endif

    assign bus.o_pc          = r_pc;
    assign bus.o_instruction = r_instruction;
    assign bus.o_pc_plus4    = r_pc_plus4;
    assign bus.o_halted      = r_halted;
endmodule

// File: tb/tb_if_stage_fetch.sv
// Bench for if_stage_fetch: directed scenarios plus randomized runs against a behavioural model.
module tb_if_stage_fetch;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam int MODE_IDLE = 0;
    localparam int MODE_RUN  = 1;
    localparam int MODE_STOP = 2;

    logic clk;
    logic rst_n;
    logic chk_en;
    int   n_cmp;
    int   n_bad;

    logic [31:0] m_mem [256];
    int          m_mode;
    logic [31:0] m_pc, m_instr, m_pc4, m_cyc, m_word;
    logic        m_halted;

    if_stage_fetch_if bus ();

    if_stage_fetch dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_mode   = MODE_IDLE;
        m_pc     = '0;
        m_instr  = '0;
        m_pc4    = '0;
        m_cyc    = '0;
        m_halted = 1'b0;
    endtask

    // Reference behaviour, evaluated from the inputs present at each rising edge.
    always @(posedge clk) begin
        if (rst_n) begin
            if (m_mode == MODE_IDLE) begin
                if (bus.i_wr_en) m_mem[bus.i_wr_addr] = bus.i_wr_data;
                if (bus.i_start) m_mode = MODE_RUN;
            end else if (m_mode == MODE_RUN) begin
                m_cyc = m_cyc + 1;
                if (bus.i_enable && !bus.i_halt) begin
                    if (bus.i_flush) begin
                        m_pc    = bus.i_jump_direction;
                        m_instr = 0;
                        m_pc4   = 0;
                    end else begin
                        m_word  = m_mem[m_pc[9:2]];
                        m_instr = m_word;
                        m_pc4   = m_pc + 4;
                        if (m_word == HALT) begin
                            m_halted = 1'b1;
                            m_mode   = MODE_STOP;
                        end else begin
                            m_pc = m_pc + 4;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc", bus.o_pc, m_pc);
            chk("instruction", bus.o_instruction, m_instr);
            chk("pc_plus4", bus.o_pc_plus4, m_pc4);
            chk("halted", {31'b0, bus.o_halted}, {31'b0, m_halted});
`ifdef IFETCH_CYCLE_COUNTER_EN
            chk("cycle_count", bus.o_cycle_count, m_cyc);
`else
            chk("cycle_count", bus.o_cycle_count, 32'd0);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_wr_en          = 1'b0;
        bus.i_wr_addr        = '0;
        bus.i_wr_data        = '0;
        bus.i_start          = 1'b0;
        bus.i_enable         = 1'b0;
        bus.i_halt           = 1'b0;
        bus.i_flush          = 1'b0;
        bus.i_jump_direction = '0;
    endtask

    function automatic logic [31:0] rand_word();
        return $urandom & 32'h7FFF_FFFF;
    endfunction

    task automatic load(input int addr, input logic [31:0] data);
        bus.i_wr_en   = 1'b1;
        bus.i_wr_addr = 8'(addr);
        bus.i_wr_data = data;
        tick();
        bus.i_wr_en   = 1'b0;
    endtask

    task automatic start();
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
    endtask

    // Reset lands between edges; outputs must clear without waiting for a clock.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        m_reset();
        clear_inputs();
        #1;
        chk("rst_pc", bus.o_pc, 32'd0);
        chk("rst_instruction", bus.o_instruction, 32'd0);
        chk("rst_pc_plus4", bus.o_pc_plus4, 32'd0);
        chk("rst_halted", {31'b0, bus.o_halted}, 32'd0);
        chk("rst_cycle_count", bus.o_cycle_count, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [31:0] old5, new5, cyc0, pc0;
    int          halt_idx [$];

    initial begin
        clk    = 1'b0;
        rst_n  = 1'b0;
        chk_en = 1'b0;
        n_cmp  = 0;
        n_bad  = 0;
        clear_inputs();
        m_reset();
        for (int i = 0; i < 256; i++) m_mem[i] = '0;
        #2;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 256; i++) load(i, rand_word());

        // Short program ending in HALT.
        load(0, 32'h2001_0005);
        load(1, 32'h2002_0007);
        load(2, HALT);
        start();
        bus.i_enable = 1'b1;
        tick();
        chk("p1_instr0", bus.o_instruction, 32'h2001_0005);
        chk("p1_pc4_0", bus.o_pc_plus4, 32'd4);
        tick();
        chk("p1_instr1", bus.o_instruction, 32'h2002_0007);
        chk("p1_pc4_1", bus.o_pc_plus4, 32'd8);
        tick();
        chk("p1_instr2", bus.o_instruction, HALT);
        chk("p1_pc4_2", bus.o_pc_plus4, 32'd12);
        chk("p1_halted", {31'b0, bus.o_halted}, 32'd1);
        chk("p1_pc_hold", bus.o_pc, 32'd8);
        load(3, 32'h1111_1111);
        bus.i_start = 1'b1;
        repeat (3) tick();
        bus.i_start = 1'b0;
        chk("p1_pc_absorb", bus.o_pc, 32'd8);
        chk("p1_halted_absorb", {31'b0, bus.o_halted}, 32'd1);

        // Flush redirect at PC=0x10.
        do_reset();
        load(2, 32'h2003_000A);
        start();
        bus.i_enable = 1'b1;
        repeat (4) tick();
        chk("fl_pc_before", bus.o_pc, 32'h10);
        bus.i_flush          = 1'b1;
        bus.i_jump_direction = 32'h40;
        tick();
        bus.i_flush = 1'b0;
        chk("fl_pc", bus.o_pc, 32'h40);
        chk("fl_instr_nop", bus.o_instruction, 32'd0);
        chk("fl_pc4_zero", bus.o_pc_plus4, 32'd0);
        tick();
        chk("fl_fetch16", bus.o_instruction, m_mem[16]);
        chk("fl_pc4_44", bus.o_pc_plus4, 32'h44);

        // Stall beats flush, then the flush is honoured.
        do_reset();
        start();
        bus.i_enable = 1'b1;
        repeat (2) tick();
        chk("hf_pc8", bus.o_pc, 32'h8);
        bus.i_halt           = 1'b1;
        bus.i_flush          = 1'b1;
        bus.i_jump_direction = 32'h30;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("hf_pc_hold", bus.o_pc, 32'h8);
            chk("hf_instr_hold", bus.o_instruction, 32'h2002_0007);
            chk("hf_pc4_hold", bus.o_pc_plus4, 32'h8);
        end
        bus.i_halt = 1'b0;
        tick();
        bus.i_flush = 1'b0;
        chk("hf_pc30", bus.o_pc, 32'h30);

        // Single-step pulses every third cycle.
        pc0  = bus.o_pc;
        cyc0 = m_cyc;
        for (int k = 0; k < 9; k++) begin
            bus.i_enable = (k % 3 == 2);
            tick();
        end
        bus.i_enable = 1'b0;
        chk("step_pc", bus.o_pc, pc0 + 32'd12);
`ifdef IFETCH_CYCLE_COUNTER_EN
        chk("step_cycles", bus.o_cycle_count, cyc0 + 32'd9);
`else
        chk("step_cycles_tied", bus.o_cycle_count, 32'd0);
`endif

        // Loader writes are dropped in RUN and accepted in IDLE.
        do_reset();
        start();
        old5 = m_mem[5];
        new5 = old5 ^ 32'h0000_1234;
        load(5, new5);
        bus.i_enable = 1'b1;
        repeat (6) tick();
        chk("ld_run_dropped", bus.o_instruction, old5);
        do_reset();
        load(5, new5);
        start();
        bus.i_enable = 1'b1;
        repeat (6) tick();
        chk("ld_idle_taken", bus.o_instruction, new5);
        repeat (3) tick();
        chk("ld_pc24", bus.o_pc, 32'h24);

        // Asynchronous reset mid-run; memory survives.
        do_reset();
        start();
        bus.i_enable = 1'b1;
        tick();
        chk("rr_refetch0", bus.o_instruction, 32'h2001_0005);
        chk("rr_pc4", bus.o_pc_plus4, 32'd4);

        // Randomized runs.
        for (int run = 0; run < 8; run++) begin
            do_reset();
            while (halt_idx.size() > 0) load(halt_idx.pop_front(), rand_word());
            for (int k = 0; k < 4; k++) load($urandom_range(0, 255), rand_word());
            if ($urandom_range(0, 1) == 1) begin
                halt_idx.push_back($urandom_range(0, 255));
                load(halt_idx[0], HALT);
            end
            start();
            for (int c = 0; c < 400; c++) begin
                bus.i_enable         = ($urandom_range(0, 9) < 7);
                bus.i_halt           = ($urandom_range(0, 9) < 2);
                bus.i_flush          = ($urandom_range(0, 9) < 2);
                bus.i_jump_direction = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h3FC);
                bus.i_start          = ($urandom_range(0, 19) == 0);
                bus.i_wr_en          = ($urandom_range(0, 9) == 0);
                bus.i_wr_addr        = 8'($urandom);
                bus.i_wr_data        = rand_word();
                tick();
            end
            clear_inputs();
        end

        tick();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
